// File: rtl/mem_write_buffer_pkg.sv
// Shared parameters and FSM encodings for the L2-to-DRAM write-back buffer.
package mem_write_buffer_pkg;

  localparam int unsigned L2_LINE_WIDTH = 128;
  localparam int unsigned WB_DEPTH      = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACK     = 2'd1;
  localparam logic [1:0] ST_RD_MISS = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  // Number of byte-offset bits below the line address.
  function automatic int unsigned line_off_bits(input int unsigned line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/mem_write_buffer_if.sv
// L2-side and DRAM-side request/response signals of the write-back buffer.
interface mem_write_buffer_if
  import mem_write_buffer_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = L2_LINE_WIDTH
);
  logic [31:0]           up_addr;
  logic [LINE_WIDTH-1:0] up_wdata;
  logic                  up_rd;
  logic                  up_wr;
  logic [LINE_WIDTH-1:0] up_rdata;
  logic                  up_ready;
  logic [31:0]           dn_addr;
  logic [LINE_WIDTH-1:0] dn_wdata;
  logic                  dn_rd;
  logic                  dn_wr;
  logic [LINE_WIDTH-1:0] dn_rdata;
  logic                  dn_ready;

  // Environment side: drives L2 requests and the DRAM response.
  modport master (
    output up_addr, up_wdata, up_rd, up_wr, dn_rdata, dn_ready,
    input  up_rdata, up_ready, dn_addr, dn_wdata, dn_rd, dn_wr
  );

  // Buffer side.
  modport slave (
    input  up_addr, up_wdata, up_rd, up_wr, dn_rdata, dn_ready,
    output up_rdata, up_ready, dn_addr, dn_wdata, dn_rd, dn_wr
  );
endinterface

// File: rtl/mem_wb_cam.sv
// Write-back entry storage with a parallel line-address match and a head read port.
module mem_wb_cam #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_W      = 28,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TAG_W-1:0]      lookup_line,
  output logic                  hit,
  output logic [PTR_W-1:0]      hit_idx,
  output logic [LINE_WIDTH-1:0] hit_data,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_line,
  input  logic [LINE_WIDTH-1:0] wr_data,
  input  logic                  clr_en,
  input  logic [PTR_W-1:0]      clr_idx,
  input  logic [PTR_W-1:0]      rd_idx,
  output logic [TAG_W-1:0]      rd_line,
  output logic [LINE_WIDTH-1:0] rd_data
);

  logic [DEPTH-1:0]      valid_q;
  logic [TAG_W-1:0]      line_q [DEPTH];
  logic [LINE_WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (clr_en) valid_q[clr_idx] <= 1'b0;
      if (wr_en)  valid_q[wr_idx]  <= 1'b1;
    end
  end

  // Payload needs no reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_q[wr_idx] <= wr_line;
      data_q[wr_idx] <= wr_data;
    end
  end

  // Merging keeps line addresses unique, so at most one entry matches.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (line_q[i] == lookup_line)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign hit_data = data_q[hit_idx];
  assign rd_line  = line_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/mem_write_buffer.sv
// Write-back buffer between L2 and DRAM: absorbs dirty lines, serves read hits,
// and drains to DRAM in FIFO order whenever L2 is quiet.
module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = L2_LINE_WIDTH,
  parameter int unsigned DEPTH      = WB_DEPTH
) (
  input logic              clk,
  input logic              rst,
  mem_write_buffer_if.slave bus
);

  localparam int unsigned OFF_BITS = line_off_bits(LINE_WIDTH);
  localparam int unsigned TAG_W    = 32 - OFF_BITS;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic                  up_ready_q, up_ready_d;
  logic [LINE_WIDTH-1:0] up_rdata_q, up_rdata_d;
  logic                  dn_rd_q, dn_rd_d, dn_wr_q, dn_wr_d;
  logic [31:0]           dn_addr_q, dn_addr_d;
  logic [LINE_WIDTH-1:0] dn_wdata_q, dn_wdata_d;

  logic [TAG_W-1:0]      up_line, head_line;
  logic                  hit;
  logic [PTR_W-1:0]      hit_idx, wr_idx;
  logic [LINE_WIDTH-1:0] hit_data, head_data;
  logic                  wr_en, clr_en;
  logic                  unused_offset;

  assign up_line       = bus.up_addr[31:OFF_BITS];
  assign unused_offset = ^bus.up_addr[OFF_BITS-1:0];

  mem_wb_cam #(
    .LINE_WIDTH (LINE_WIDTH),
    .DEPTH      (DEPTH),
    .TAG_W      (TAG_W)
  ) u_cam (
    .clk         (clk),
    .rst         (rst),
    .lookup_line (up_line),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .hit_data    (hit_data),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_line     (up_line),
    .wr_data     (bus.up_wdata),
    .clr_en      (clr_en),
    .clr_idx     (head_q),
    .rd_idx      (head_q),
    .rd_line     (head_line),
    .rd_data     (head_data)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    up_ready_d = up_ready_q;
    up_rdata_d = up_rdata_q;
    dn_rd_d    = dn_rd_q;
    dn_wr_d    = dn_wr_q;
    dn_addr_d  = dn_addr_q;
    dn_wdata_d = dn_wdata_q;
    wr_en      = 1'b0;
    wr_idx     = tail_q;
    clr_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // L2 requests win over draining; a full-and-miss write forces a drain.
        if (bus.up_wr && (hit || (count_q != COUNT_FULL))) begin
          wr_en      = 1'b1;
          up_ready_d = 1'b1;
          state_d    = ST_ACK;
          if (hit) begin
            wr_idx = hit_idx;
          end else begin
            tail_d  = tail_q + PTR_W'(1);
            count_d = count_q + CNT_W'(1);
          end
        end else if (bus.up_rd && hit) begin
          up_rdata_d = hit_data;
          up_ready_d = 1'b1;
          state_d    = ST_ACK;
        end else if (bus.up_rd) begin
          dn_rd_d   = 1'b1;
          dn_addr_d = {up_line, {OFF_BITS{1'b0}}};
          state_d   = ST_RD_MISS;
        end else if (count_q != '0) begin
          dn_wr_d    = 1'b1;
          dn_addr_d  = {head_line, {OFF_BITS{1'b0}}};
          dn_wdata_d = head_data;
          state_d    = ST_DRAIN;
        end
      end
      ST_ACK: begin
        up_ready_d = 1'b0;
        state_d    = ST_IDLE;
      end
      ST_RD_MISS: begin
        if (bus.dn_ready) begin
          dn_rd_d    = 1'b0;
          up_rdata_d = bus.dn_rdata;
          up_ready_d = 1'b1;
          state_d    = ST_ACK;
        end
      end
      ST_DRAIN: begin
        if (bus.dn_ready) begin
          dn_wr_d = 1'b0;
          clr_en  = 1'b1;
          head_d  = head_q + PTR_W'(1);
          count_d = count_q - CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      up_ready_q <= 1'b0;
      up_rdata_q <= '0;
      dn_rd_q    <= 1'b0;
      dn_wr_q    <= 1'b0;
      dn_addr_q  <= '0;
      dn_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      up_ready_q <= up_ready_d;
      up_rdata_q <= up_rdata_d;
      dn_rd_q    <= dn_rd_d;
      dn_wr_q    <= dn_wr_d;
      dn_addr_q  <= dn_addr_d;
      dn_wdata_q <= dn_wdata_d;
    end
  end

  assign bus.up_ready = up_ready_q;
  assign bus.up_rdata = up_rdata_q;
  assign bus.dn_rd    = dn_rd_q;
  assign bus.dn_wr    = dn_wr_q;
  assign bus.dn_addr  = dn_addr_q;
  assign bus.dn_wdata = dn_wdata_q;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer against a fixed-latency DRAM model.
module tb_mem_write_buffer;

  localparam int unsigned LW  = 128;
  localparam int          LAT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_write_buffer_if #(.LINE_WIDTH(LW)) bus ();

  mem_write_buffer #(
    .LINE_WIDTH (LW),
    .DEPTH      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] dram_init(input logic [31:0] a);
    return {4{a ^ 32'hA5A5_0000}};
  endfunction

  // DRAM model: responds LAT cycles after a request appears, reset with the DUT.
  logic [LW-1:0] mem [4096];
  logic [4095:0] mem_v = '0;
  int            dcnt = 0;
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic [31:0]   wr_log_addr [64];
  logic [LW-1:0] wr_log_data [64];
  logic [31:0]   rd_last_addr = '0;

  always @(posedge clk) begin
    if (rst) begin
      bus.dn_ready <= 1'b0;
      bus.dn_rdata <= '0;
      dcnt         <= 0;
    end else begin
      bus.dn_ready <= 1'b0;
      if ((bus.dn_rd || bus.dn_wr) && !bus.dn_ready) begin
        if (dcnt == LAT - 1) begin
          dcnt         <= 0;
          bus.dn_ready <= 1'b1;
          if (bus.dn_wr) begin
            mem[bus.dn_addr[15:4]]   <= bus.dn_wdata;
            mem_v[bus.dn_addr[15:4]] <= 1'b1;
            wr_log_addr[wr_cnt[5:0]] <= bus.dn_addr;
            wr_log_data[wr_cnt[5:0]] <= bus.dn_wdata;
            wr_cnt                   <= wr_cnt + 1;
          end else begin
            bus.dn_rdata <= mem_v[bus.dn_addr[15:4]] ? mem[bus.dn_addr[15:4]]
                                                     : dram_init(bus.dn_addr);
            rd_last_addr <= bus.dn_addr;
            rd_cnt       <= rd_cnt + 1;
          end
        end else begin
          dcnt <= dcnt + 1;
        end
      end
    end
  end

  task automatic do_reset();
    rst        = 1'b1;
    bus.up_rd  = 1'b0;
    bus.up_wr  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called right after a negedge; returns right after the negedge that follows the pulse.
  task automatic up_op(input bit is_wr, input logic [31:0] a, input logic [LW-1:0] d,
                       output int cyc, output logic [LW-1:0] rdata, output int rd_hi);
    cyc          = 0;
    rd_hi        = 0;
    bus.up_addr  = a;
    bus.up_wdata = d;
    bus.up_wr    = is_wr;
    bus.up_rd    = !is_wr;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.dn_rd) rd_hi++;
      if (bus.up_ready) break;
    end
    check("ready_seen", LW'(bus.up_ready), LW'(1));
    rdata     = bus.up_rdata;
    bus.up_wr = 1'b0;
    bus.up_rd = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", LW'(bus.up_ready), LW'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int            cyc, rd_hi, wbase, rbase;
    logic [LW-1:0] rdata;
    bus.up_addr  = '0;
    bus.up_wdata = '0;
    bus.up_rd    = 1'b0;
    bus.up_wr    = 1'b0;

    // Reset state
    do_reset();
    check("rst_up_ready", LW'(bus.up_ready), LW'(0));
    check("rst_up_rdata", bus.up_rdata, '0);
    check("rst_dn_rd", LW'(bus.dn_rd), LW'(0));
    check("rst_dn_wr", LW'(bus.dn_wr), LW'(0));
    check("rst_dn_addr", LW'(bus.dn_addr), LW'(0));
    check("rst_dn_wdata", bus.dn_wdata, '0);
    check("rst_count", LW'(dut.count_q), LW'(0));

    // Write then read hit on the same line
    rbase = rd_cnt;
    up_op(1'b1, 32'h1000, 128'hAAAA_0001, cyc, rdata, rd_hi);
    check("wr_latency", LW'(cyc), LW'(1));
    up_op(1'b0, 32'h1000, '0, cyc, rdata, rd_hi);
    check("rd_hit_latency", LW'(cyc), LW'(1));
    check("rd_hit_data", rdata, 128'hAAAA_0001);
    check("rd_hit_no_dn_rd", LW'(rd_hi), LW'(0));
    check("rd_hit_no_dram", LW'(rd_cnt - rbase), LW'(0));

    // Merge: two writes to one line leave one entry and one DRAM write
    do_reset();
    wbase = wr_cnt;
    up_op(1'b1, 32'h2000, 128'hBBBB, cyc, rdata, rd_hi);
    up_op(1'b1, 32'h2000, 128'hCCCC, cyc, rdata, rd_hi);
    check("merge_latency", LW'(cyc), LW'(1));
    up_op(1'b0, 32'h2008, '0, cyc, rdata, rd_hi);
    check("merge_rd_newest", rdata, 128'hCCCC);
    check("merge_count", LW'(dut.count_q), LW'(1));
    repeat (40) @(negedge clk);
    check("merge_single_wr", LW'(wr_cnt - wbase), LW'(1));
    check("merge_wr_addr", LW'(wr_log_addr[wbase[5:0]]), LW'(32'h2000));
    check("merge_wr_data", wr_log_data[wbase[5:0]], 128'hCCCC);
    check("merge_count_zero", LW'(dut.count_q), LW'(0));
    up_op(1'b0, 32'h2000, '0, cyc, rdata, rd_hi);
    check("raw_after_drain", rdata, 128'hCCCC);

    // Full buffer: fifth write waits for the head to drain
    do_reset();
    wbase = wr_cnt;
    for (int i = 1; i <= 4; i++) begin
      up_op(1'b1, 32'(i) << 12, LW'(32'h1100 + i), cyc, rdata, rd_hi);
    end
    check("full_count", LW'(dut.count_q), LW'(4));
    check("full_no_drain_yet", LW'(wr_cnt - wbase), LW'(0));
    up_op(1'b1, 32'h5000, 128'h1105, cyc, rdata, rd_hi);
    check("full_stall_cycles", LW'(cyc), LW'(LAT + 3));
    check("full_head_drained", LW'(wr_log_addr[wbase[5:0]]), LW'(32'h1000));
    repeat (80) @(negedge clk);
    check("full_total_wr", LW'(wr_cnt - wbase), LW'(5));
    check("full_last_addr", LW'(wr_log_addr[6'(wbase + 4)]), LW'(32'h5000));
    check("full_last_data", wr_log_data[6'(wbase + 4)], 128'h1105);

    // Read miss with an unaligned address
    do_reset();
    rbase = rd_cnt;
    up_op(1'b0, 32'h800C, '0, cyc, rdata, rd_hi);
    check("miss_latency", LW'(cyc), LW'(LAT + 2));
    check("miss_dn_rd_held", LW'(rd_hi), LW'(LAT + 1));
    check("miss_data", rdata, dram_init(32'h8000));
    check("miss_aligned_addr", LW'(rd_last_addr), LW'(32'h8000));
    check("miss_one_dram_rd", LW'(rd_cnt - rbase), LW'(1));

    // Idle drain order, then reads come back from DRAM
    do_reset();
    wbase = wr_cnt;
    for (int i = 1; i <= 3; i++) begin
      up_op(1'b1, 32'(i) << 12, LW'(32'hD000 + i), cyc, rdata, rd_hi);
    end
    repeat (60) @(negedge clk);
    check("drain_count_zero", LW'(dut.count_q), LW'(0));
    for (int i = 0; i < 3; i++) begin
      check("drain_order_addr", LW'(wr_log_addr[6'(wbase + i)]), LW'(32'(i + 1) << 12));
      check("drain_order_data", wr_log_data[6'(wbase + i)], LW'(32'hD001 + i));
    end
    rbase = rd_cnt;
    for (int i = 1; i <= 3; i++) begin
      up_op(1'b0, 32'(i) << 12, '0, cyc, rdata, rd_hi);
      check("drain_readback", rdata, LW'(32'hD000 + i));
    end
    check("drain_reads_dram", LW'(rd_cnt - rbase), LW'(3));

    // Reset in the middle of a drain discards the line
    do_reset();
    wbase = wr_cnt;
    up_op(1'b1, 32'h9000, 128'hEEEE, cyc, rdata, rd_hi);
    cyc = 0;
    while (!bus.dn_wr && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_drain_started", LW'(bus.dn_wr), LW'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_dn_wr", LW'(bus.dn_wr), LW'(0));
    check("mid_rst_count", LW'(dut.count_q), LW'(0));
    rst = 1'b0;
    rbase = rd_cnt;
    up_op(1'b0, 32'h9000, '0, cyc, rdata, rd_hi);
    check("mid_rst_rd_dram", LW'(rd_cnt - rbase), LW'(1));
    check("mid_rst_rd_data", rdata, dram_init(32'h9000));
    check("mid_rst_no_wr", LW'(wr_cnt - wbase), LW'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
